// File: rtl/pass_keeper_pkg.sv
// Shared reason codes and FSM state encoding for the password-verification stage.
package pass_keeper_pkg;

  localparam logic [1:0] REASON_OK      = 2'b00;
  localparam logic [1:0] REASON_NOUSER  = 2'b01;
  localparam logic [1:0] REASON_BADPASS = 2'b10;
  localparam logic [1:0] REASON_LOCKED  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/pass_ram.sv
// Stored-password RAM: one write port, one synchronous read port, contents not reset.
module pass_ram #(
  parameter int ADDR_WIDTH = 2,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [PASS_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [PASS_WIDTH-1:0] rdata
);

  logic [PASS_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pass_check.sv
// Password verification after CAM lookup: verdict with reason code, per-slot
// consecutive-failure tracking and a global lockout timer.
//
// state   | meaning
// S_IDLE  | waiting; accepts a request or a password write
// S_READ  | RAM read of the captured slot in progress
// S_CHECK | verdict evaluated, counters and lock timer updated
// S_RESP  | verdict handed to the output registers (done follows)
module pass_check
  import pass_keeper_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int PASS_WIDTH  = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  match,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  input  logic [PASS_WIDTH-1:0] pass_in,
  input  logic                  pw_we,
  input  logic [ADDR_WIDTH-1:0] pw_addr,
  input  logic [PASS_WIDTH-1:0] pw_din,
  output logic                  busy,
  output logic                  done,
  output logic                  grant,
  output logic [1:0]            reason,
  output logic                  locked
);

  localparam int SLOTS  = 2**ADDR_WIDTH;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCK_CYCLES);

  state_t                  state_q, state_d;
  logic                    match_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [PASS_WIDTH-1:0]   pass_q;
  logic [SLOTS-1:0]        valid_q;
  logic [FAIL_W-1:0]       fails_q [SLOTS];
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [PASS_WIDTH-1:0]   stored;
  logic                    accept, wr_en, lock_now, trip, reload;
  logic [1:0]              verdict;
  logic [FAIL_W-1:0]       fail_inc;
  logic                    busy_d, done_d, locked_d;

  // busy stays high through the done cycle, so IDLE only listens once it drops
  assign accept = (state_q == S_IDLE) && !busy && req_valid;
  assign wr_en  = (state_q == S_IDLE) && !busy && !req_valid && pw_we;

  pass_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PASS_WIDTH(PASS_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(pw_addr),
    .wdata(pw_din),
    .raddr(addr_q),
    .rdata(stored)
  );

  // A timer at 1 expires on the CHECK edge itself, which does not count as locked
  assign lock_now = timer_q > TMR_W'(1);
  assign fail_inc = (fails_q[addr_q] == FAIL_MAX) ? FAIL_MAX : fails_q[addr_q] + FAIL_W'(1);
  assign trip     = (fail_inc == FAIL_MAX);

  always_comb begin
    verdict = REASON_OK;
    if (lock_now)                            verdict = REASON_LOCKED;
    else if (!match_q || !valid_q[addr_q])   verdict = REASON_NOUSER;
    else if (stored != pass_q)               verdict = REASON_BADPASS;
  end

  assign reload = (state_q == S_CHECK) && (verdict == REASON_BADPASS) && trip;

  always_comb begin
    timer_d = timer_q;
    if (reload)                timer_d = TMR_LOAD;
    else if (timer_q != '0)    timer_d = timer_q - TMR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d   = (state_q == S_RESP);
    busy_d   = (state_d != S_IDLE) || (state_q == S_RESP);
    locked_d = (timer_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      match_q <= 1'b0;
      addr_q  <= '0;
      pass_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) fails_q[i] <= '0;
      timer_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      grant   <= 1'b0;
      reason  <= REASON_OK;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      busy    <= busy_d;
      done    <= done_d;
      locked  <= locked_d;
      if (accept) begin
        match_q <= match;
        addr_q  <= match_addr;
        pass_q  <= pass_in;
      end
      if (wr_en) begin
        valid_q[pw_addr] <= 1'b1;
        fails_q[pw_addr] <= '0;
      end
      if (state_q == S_CHECK) begin
        grant  <= (verdict == REASON_OK);
        reason <= verdict;
        if (verdict == REASON_OK) begin
          fails_q[addr_q] <= '0;
        end else if (verdict == REASON_BADPASS) begin
          if (trip) for (int i = 0; i < SLOTS; i++) fails_q[i] <= '0;
          else      fails_q[addr_q] <= fail_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pass_check.sv
// Bench for pass_check: table of requests/writes plus lockout, collision and reset sequences.
module tb_pass_check;
  import pass_keeper_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, match, pw_we;
  logic [1:0] match_addr, pw_addr;
  logic [7:0] pass_in, pw_din;
  logic       busy, done, grant, locked;
  logic [1:0] reason;

  pass_check #(
    .ADDR_WIDTH(2), .PASS_WIDTH(8), .MAX_FAILS(3), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .match(match),
    .match_addr(match_addr), .pass_in(pass_in), .pw_we(pw_we),
    .pw_addr(pw_addr), .pw_din(pw_din), .busy(busy), .done(done),
    .grant(grant), .reason(reason), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected {grant, reason} and the cycle the request was accepted
  typedef struct {
    logic [2:0] exp;
    int         acc;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  typedef struct {
    bit         wr;
    bit         m;
    logic [1:0] a;
    logic [7:0] d;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  int   busy_run   = 0;
  int   lock_len   = 0;
  int   lock_start = -1;
  logic locked_prev = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 with no request pending (cycle %0d)", cyc);
      end else begin
        sb_e = sb_q.pop_front();
        chk("grant", 32'(grant), 32'(sb_e.exp[2]));
        chk("reason", 32'(reason), 32'(sb_e.exp[1:0]));
        chk("done_latency", 32'(cyc - sb_e.acc), 32'd3);
      end
    end
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) chk("busy_cycles", 32'(busy_run), 32'd4);
      busy_run = 0;
    end
    if (locked) lock_len++;
    if (locked && !locked_prev) lock_start = cyc;
    locked_prev = locked;
  end

  task automatic wait_free();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 60);
    if (busy) begin
      n_total++;
      $display("FAIL wait_free_timeout: busy still 1 after %0d cycles", t);
    end
  endtask

  task automatic send_req(input bit m, input logic [1:0] a, input logic [7:0] p,
                          input bit push, input logic [2:0] exp,
                          input bit wr, input logic [7:0] wd);
    wait_free();
    req_valid  = 1'b1;
    match      = m;
    match_addr = a;
    pass_in    = p;
    pw_we      = wr;
    pw_addr    = a;
    pw_din     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pw_we     = 1'b0;
    if (push) sb_q.push_back('{exp: exp, acc: cyc});
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    wait_free();
    pw_we   = 1'b1;
    pw_addr = a;
    pw_din  = d;
    @(posedge clk);
    #1;
    pw_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0 || busy) begin
      n_total++;
      $display("FAIL wait_idle_timeout: %0d verdicts outstanding, busy=%0b", sb_q.size(), busy);
    end
  endtask

  initial begin
    // {wr, match, addr, data/pass, expected {grant, reason}}
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'h00, 3'b001};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 8'hA5, 3'b000};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 8'hA5, 3'b100};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 8'hA5, 3'b001};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h00, 3'b010};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 8'h00, 3'b010};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 8'hA5, 3'b100};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h00, 3'b010};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 8'h00, 3'b010};
    tbl[9]  = '{1'b1, 1'b0, 2'd3, 8'h3C, 3'b000};
    tbl[10] = '{1'b0, 1'b1, 2'd3, 8'h3C, 3'b100};
    tbl[11] = '{1'b0, 1'b1, 2'd3, 8'h3D, 3'b010};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 8'hA5, 3'b100};

    rst = 1'b1;
    req_valid = 1'b0; match = 1'b0; match_addr = '0; pass_in = '0;
    pw_we = 1'b0; pw_addr = '0; pw_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_reason", 32'(reason), 32'(REASON_OK));
    chk("reset_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d);
      else send_req(tbl[i].m, tbl[i].a, tbl[i].d, 1'b1, tbl[i].exp, 1'b0, 8'h00);
    end
    wait_idle();
    chk("no_lock_after_success_clear", 32'(locked), 32'd0);

    // two failures, a no-user request that must not touch counters, then the tripping failure
    send_req(1'b1, 2'd1, 8'h00, 1'b1, 3'b010, 1'b0, 8'h00);
    send_req(1'b1, 2'd1, 8'h00, 1'b1, 3'b010, 1'b0, 8'h00);
    send_req(1'b0, 2'd1, 8'h00, 1'b1, 3'b001, 1'b0, 8'h00);
    send_req(1'b1, 2'd1, 8'h00, 1'b1, 3'b010, 1'b0, 8'h00);
    wait_idle();
    chk("locked_after_trip", 32'(locked), 32'd1);

    // lockout loaded on edge lock_start: CHECK at lock_start+11 is locked, at +16 it is not
    while (cyc < lock_start + 7) @(negedge clk);
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b011, 1'b0, 8'h00);
    chk("locked_probe_accept_cycle", 32'(cyc - lock_start), 32'd9);
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b100, 1'b0, 8'h00);
    chk("expiry_probe_accept_cycle", 32'(cyc - lock_start), 32'd14);
    wait_idle();
    chk("lock_duration", 32'(lock_len), 32'd16);
    chk("unlocked_after_expiry", 32'(locked), 32'd0);

    // request and write together: the write is dropped
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b100, 1'b1, 8'h11);
    // write attempted while busy: ignored
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b100, 1'b0, 8'h00);
    pw_we = 1'b1; pw_addr = 2'd1; pw_din = 8'h22;
    repeat (3) @(negedge clk);
    pw_we = 1'b0;
    wait_idle();
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b100, 1'b0, 8'h00);
    wait_idle();

    // reset while in READ abandons the request
    send_req(1'b1, 2'd1, 8'hA5, 1'b0, 3'b000, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_grant", 32'(grant), 32'd0);
    chk("midreset_reason", 32'(reason), 32'(REASON_OK));
    chk("midreset_locked", 32'(locked), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send_req(1'b1, 2'd1, 8'hA5, 1'b1, 3'b001, 1'b0, 8'h00);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
